// File: rtl/lut_table_ctl.sv
// 256x32 lookup table: post-reset zero-fill, 2-cycle pipelined reads, loader writes win over reads.
// Optional per-entry even parity selected by LUT_TABLE_CTL_PARITY_EN (Par_Err tied low otherwise).
module lut_table_ctl (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [7:0]  TIE_lut_Out,
  input  logic        TIE_lut_Out_Req,
  output logic        TIE_lut_Rdy,
  output logic [31:0] TIE_lut_In,
  output logic        TIE_lut_In_Valid,
  input  logic        Wr_En,
  input  logic [7:0]  Wr_Addr,
  input  logic [31:0] Wr_Data,
  input  logic        Wr_Par_Flip,
  output logic        Init_Done,
  output logic        Par_Err
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        init_done_q, init_done_d;

  logic        rd1_vld_q, rd1_vld_d;
  logic [7:0]  rd1_addr_q, rd1_addr_d;
  logic        rd2_vld_q, rd2_vld_d;
  logic [31:0] rd2_dat_q, rd2_dat_d;

  logic        out_vld_q, out_vld_d;
  logic [31:0] out_dat_q, out_dat_d;
  logic        par_err_q, par_err_d;

  logic [31:0] mem_q [0:255];
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdat;
  logic        rdy;
  logic        accept;

`ifdef LUT_TABLE_CTL_PARITY_EN
  logic        par_mem_q [0:255];
  logic        mem_wpar;
  logic        rd2_par_q, rd2_par_d;
`else
  logic        unused_par_flip;
  assign unused_par_flip = Wr_Par_Flip;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = Wr_Addr;
    mem_wdat    = Wr_Data;
    rdy         = 1'b0;
`ifdef LUT_TABLE_CTL_PARITY_EN
    mem_wpar    = (^Wr_Data) ^ Wr_Par_Flip;
`endif
    case (state_q)
      ST_INIT: begin
        // Loader writes are ignored here; the clear owns the write port.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdat  = 32'd0;
`ifdef LUT_TABLE_CTL_PARITY_EN
        mem_wpar  = 1'b0;
`endif
        cnt_d     = cnt_q + 8'd1;
        if (cnt_q == 8'd255) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        mem_we = Wr_En;
        rdy    = ~Wr_En;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign accept = TIE_lut_Out_Req & rdy;

  // Stage 1 captures the address, stage 2 reads the array, stage 3 registers the result.
  always_comb begin
    rd1_vld_d  = accept;
    rd1_addr_d = accept ? TIE_lut_Out : rd1_addr_q;
    rd2_vld_d  = rd1_vld_q;
    rd2_dat_d  = rd1_vld_q ? mem_q[rd1_addr_q] : rd2_dat_q;
    out_vld_d  = rd2_vld_q;
    out_dat_d  = rd2_vld_q ? rd2_dat_q : out_dat_q;
`ifdef LUT_TABLE_CTL_PARITY_EN
    rd2_par_d  = rd1_vld_q ? par_mem_q[rd1_addr_q] : rd2_par_q;
    par_err_d  = rd2_vld_q & ((^rd2_dat_q) != rd2_par_q);
`else
    par_err_d  = 1'b0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= 8'd0;
      init_done_q <= 1'b0;
      rd1_vld_q   <= 1'b0;
      rd1_addr_q  <= 8'd0;
      rd2_vld_q   <= 1'b0;
      rd2_dat_q   <= 32'd0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= 32'd0;
      par_err_q   <= 1'b0;
`ifdef LUT_TABLE_CTL_PARITY_EN
      rd2_par_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd1_vld_q   <= rd1_vld_d;
      rd1_addr_q  <= rd1_addr_d;
      rd2_vld_q   <= rd2_vld_d;
      rd2_dat_q   <= rd2_dat_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      par_err_q   <= par_err_d;
`ifdef LUT_TABLE_CTL_PARITY_EN
      rd2_par_q   <= rd2_par_d;
`endif
    end
  end

  // No reset on the array: contents come only from the INIT clear and loader writes.
  always_ff @(posedge CLK) begin
    if (Reset_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdat;
`ifdef LUT_TABLE_CTL_PARITY_EN
      par_mem_q[mem_waddr] <= mem_wpar;
`endif
    end
  end

  assign TIE_lut_Rdy      = rdy;
  assign TIE_lut_In       = out_dat_q;
  assign TIE_lut_In_Valid = out_vld_q;
  assign Init_Done        = init_done_q;
  assign Par_Err          = par_err_q;

endmodule

// File: tb/tb_lut_table_ctl.sv
// Directed bench for lut_table_ctl: init sequencing, read latency, write priority, reset abort, parity.
module tb_lut_table_ctl;

  logic        clk;
  logic        reset_n;
  logic [7:0]  lut_out;
  logic        lut_out_req;
  logic        lut_rdy;
  logic [31:0] lut_in;
  logic        lut_in_vld;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_par_flip;
  logic        init_done;
  logic        par_err;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef LUT_TABLE_CTL_PARITY_EN
  localparam logic PERR_FLIP = 1'b1;
`else
  localparam logic PERR_FLIP = 1'b0;
`endif

  lut_table_ctl dut (
    .CLK              (clk),
    .Reset_n          (reset_n),
    .TIE_lut_Out      (lut_out),
    .TIE_lut_Out_Req  (lut_out_req),
    .TIE_lut_Rdy      (lut_rdy),
    .TIE_lut_In       (lut_in),
    .TIE_lut_In_Valid (lut_in_vld),
    .Wr_En            (wr_en),
    .Wr_Addr          (wr_addr),
    .Wr_Data          (wr_data),
    .Wr_Par_Flip      (wr_par_flip),
    .Init_Done        (init_done),
    .Par_Err          (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic flip);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_par_flip = flip;
    step();
    wr_en = 1'b0; wr_par_flip = 1'b0;
  endtask

  // Accept on the next edge, then expect the result exactly two edges later.
  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp, input logic exp_perr);
    lut_out = a; lut_out_req = 1'b1;
    #1;
    chk({tag, "_rdy"}, {31'd0, lut_rdy}, 32'd1);
    step();
    lut_out_req = 1'b0;
    step();
    chk({tag, "_vld_early"}, {31'd0, lut_in_vld}, 32'd0);
    step();
    chk({tag, "_vld"}, {31'd0, lut_in_vld}, 32'd1);
    chk({tag, "_dat"}, lut_in, exp);
    chk({tag, "_perr"}, {31'd0, par_err}, {31'd0, exp_perr});
  endtask

  initial begin
    int bad;
    reset_n = 1'b0; lut_out = 8'h00; lut_out_req = 1'b0;
    wr_en = 1'b0; wr_addr = 8'h00; wr_data = 32'd0; wr_par_flip = 1'b0;
    step();
    step();
    chk("rst_rdy",  {31'd0, lut_rdy},    32'd0);
    chk("rst_in",   lut_in,              32'd0);
    chk("rst_vld",  {31'd0, lut_in_vld}, 32'd0);
    chk("rst_done", {31'd0, init_done},  32'd0);
    chk("rst_perr", {31'd0, par_err},    32'd0);

    // INIT: request held at 0x10 through the whole clear.
    reset_n = 1'b1; lut_out = 8'h10; lut_out_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (lut_rdy || init_done || lut_in_vld) bad++;
      step();
    end
    chk("init_rdy_low_256", bad, 0);
    chk("init_done_c257", {31'd0, init_done}, 32'd1);
    chk("rdy_c257", {31'd0, lut_rdy}, 32'd1);
    step();
    lut_out_req = 1'b0;
    chk("first_vld_acc0", {31'd0, lut_in_vld}, 32'd0);
    step();
    chk("first_vld_acc1", {31'd0, lut_in_vld}, 32'd0);
    step();
    chk("first_vld_acc2", {31'd0, lut_in_vld}, 32'd1);
    chk("first_dat", lut_in, 32'h0000_0000);
    step();
    chk("first_vld_pulse", {31'd0, lut_in_vld}, 32'd0);

    wr(8'h05, 32'hDEAD_BEEF, 1'b0);
    rd("raw05", 8'h05, 32'hDEAD_BEEF, 1'b0);

    wr(8'h01, 32'h0000_0011, 1'b0);
    wr(8'h02, 32'h0000_0022, 1'b0);
    wr(8'h03, 32'h0000_0033, 1'b0);
    lut_out_req = 1'b1;
    lut_out = 8'h01; step();
    lut_out = 8'h02; step();
    chk("b2b_vld_a1", {31'd0, lut_in_vld}, 32'd0);
    lut_out = 8'h03; step();
    lut_out_req = 1'b0;
    chk("b2b_vld0", {31'd0, lut_in_vld}, 32'd1);
    chk("b2b_dat0", lut_in, 32'h11);
    step();
    chk("b2b_vld1", {31'd0, lut_in_vld}, 32'd1);
    chk("b2b_dat1", lut_in, 32'h22);
    step();
    chk("b2b_vld2", {31'd0, lut_in_vld}, 32'd1);
    chk("b2b_dat2", lut_in, 32'h33);
    step();
    chk("b2b_vld_end", {31'd0, lut_in_vld}, 32'd0);
    step();
    chk("hold_dat", lut_in, 32'h33);

    // Write and request in the same cycle: write wins, request waits one cycle.
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 32'hCAFE_F00D;
    lut_out = 8'h20; lut_out_req = 1'b1;
    #1;
    chk("coll_rdy_low", {31'd0, lut_rdy}, 32'd0);
    step();
    wr_en = 1'b0;
    chk("coll_no_vld", {31'd0, lut_in_vld}, 32'd0);
    rd("coll", 8'h20, 32'hCAFE_F00D, 1'b0);

    // Reset one cycle after an accept: in-flight read is dropped.
    lut_out = 8'h05; lut_out_req = 1'b1;
    step();
    lut_out_req = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_vld", {31'd0, lut_in_vld}, 32'd0);
    chk("abort_in", lut_in, 32'd0);
    chk("abort_done", {31'd0, init_done}, 32'd0);
    wr_en = 1'b1; wr_addr = 8'h05; wr_data = 32'h1234_5678;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 8) wr_en = 1'b0;
      #1;
      if (lut_in_vld || init_done || lut_rdy) bad++;
      step();
    end
    wr_en = 1'b0;
    chk("reinit_quiet", bad, 0);
    chk("reinit_done", {31'd0, init_done}, 32'd1);
    rd("cleared05", 8'h05, 32'd0, 1'b0);
    rd("cleared01", 8'h01, 32'd0, 1'b0);

    wr(8'h30, 32'h0000_0001, 1'b1);
    rd("par_flip", 8'h30, 32'h0000_0001, PERR_FLIP);
    wr(8'h31, 32'h0000_0003, 1'b0);
    rd("par_ok", 8'h31, 32'h0000_0003, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
